// File: rtl/io_input_cond.sv
// rtl/io_input_cond.sv - sync, debounce, press pulse and sticky flags for board buttons/switches
// Define IO_SW_DEBOUNCE_EN to run switches through the button debounce filter.
module io_input_cond #(
    parameter int N_BTN  = 4,
    parameter int N_SW   = 32,
    parameter int DB_CNT = 1000,
    parameter int CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn_raw,
    input  logic [N_SW-1:0]  i_sw_raw,
    output logic [N_BTN-1:0] o_io_btn,
    output logic [N_SW-1:0]  o_io_sw,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_BTN-1:0] o_btn_sticky,
    input  logic [N_BTN-1:0] i_sticky_clr,
    output logic             o_sw_chg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    generate
        if (DB_CNT < 2 || DB_CNT > (2 ** CNT_W) - 1) begin : g_bad_db_cnt
            $error("io_input_cond: DB_CNT out of range for CNT_W");
        end
    endgenerate

    logic [N_BTN-1:0] btn_s1, btn_s2, btn_db, btn_db_nxt;
    logic [N_BTN-1:0] btn_press, btn_sticky;
    logic [CNT_W-1:0] btn_cnt     [N_BTN];
    logic [CNT_W-1:0] btn_cnt_nxt [N_BTN];

    logic [N_SW-1:0]  sw_s1, sw_s2, sw_lvl, sw_prev;
    logic             sw_chg;

    // Any cycle of agreement with the current level restarts the count.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            btn_db_nxt[i]  = btn_db[i];
            btn_cnt_nxt[i] = '0;
            if (btn_s2[i] != btn_db[i]) begin
                if (btn_cnt[i] == CNT_LAST) begin
                    btn_db_nxt[i] = btn_s2[i];
                end else begin
                    btn_cnt_nxt[i] = btn_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            btn_s1     <= '0;
            btn_s2     <= '0;
            btn_db     <= '0;
            btn_press  <= '0;
            btn_sticky <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                btn_cnt[i] <= '0;
            end
            sw_s1   <= '0;
            sw_s2   <= '0;
            sw_prev <= '0;
            sw_chg  <= 1'b0;
        end else begin
            btn_s1     <= i_btn_raw;
            btn_s2     <= btn_s1;
            btn_db     <= btn_db_nxt;
            btn_press  <= btn_db_nxt & ~btn_db;
            // A press landing on the same edge as a clear keeps the flag set.
            btn_sticky <= (btn_sticky & ~i_sticky_clr) | (btn_db_nxt & ~btn_db);
            for (int i = 0; i < N_BTN; i++) begin
                btn_cnt[i] <= btn_cnt_nxt[i];
            end
            sw_s1   <= i_sw_raw;
            sw_s2   <= sw_s1;
            sw_prev <= sw_lvl;
            sw_chg  <= (sw_lvl != sw_prev);
        end
    end

`ifdef IO_SW_DEBOUNCE_EN
    logic [N_SW-1:0]  sw_db, sw_db_nxt;
    logic [CNT_W-1:0] sw_cnt     [N_SW];
    logic [CNT_W-1:0] sw_cnt_nxt [N_SW];

    always_comb begin
        for (int i = 0; i < N_SW; i++) begin
            sw_db_nxt[i]  = sw_db[i];
            sw_cnt_nxt[i] = '0;
            if (sw_s2[i] != sw_db[i]) begin
                if (sw_cnt[i] == CNT_LAST) begin
                    sw_db_nxt[i] = sw_s2[i];
                end else begin
                    sw_cnt_nxt[i] = sw_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_db <= '0;
            for (int i = 0; i < N_SW; i++) begin
                sw_cnt[i] <= '0;
            end
        end else begin
            sw_db <= sw_db_nxt;
            for (int i = 0; i < N_SW; i++) begin
                sw_cnt[i] <= sw_cnt_nxt[i];
            end
        end
    end

    assign sw_lvl = sw_db;
`else
    assign sw_lvl = sw_s2;
`endif

    assign o_io_btn     = btn_db;
    assign o_btn_press  = btn_press;
    assign o_btn_sticky = btn_sticky;
    assign o_io_sw      = sw_lvl;
    assign o_sw_chg     = sw_chg;

endmodule

// File: tb/tb_io_input_cond.sv
// tb/tb_io_input_cond.sv - randomized self-checking bench for io_input_cond
// Reference model: a level flips once DB consecutive synchronised samples all disagree with it.
module tb_io_input_cond;

    localparam int NB = 4;
    localparam int NS = 32;
    localparam int DB = 8;
    localparam int VW = 3 * NB + NS + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NB-1:0] btn_raw, clr;
    logic [NS-1:0] sw_raw;
    logic [NB-1:0] io_btn, btn_press, btn_sticky;
    logic [NS-1:0] io_sw;
    logic          sw_chg;

    int checks = 0;
    int errors = 0;

    io_input_cond #(.N_BTN(NB), .N_SW(NS), .DB_CNT(DB), .CNT_W(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn_raw    (btn_raw),
        .i_sw_raw     (sw_raw),
        .o_io_btn     (io_btn),
        .o_io_sw      (io_sw),
        .o_btn_press  (btn_press),
        .o_btn_sticky (btn_sticky),
        .i_sticky_clr (clr),
        .o_sw_chg     (sw_chg)
    );

    logic [NB-1:0] m_b1, m_b2, m_bdb, m_press, m_sticky, m_nb;
    logic [NS-1:0] m_s1, m_s2, m_sw, m_swprev, m_nsw, m_old;
    logic          m_chg;
    logic [NS-1:0] bq[$];
    logic [NS-1:0] sq[$];

    function automatic logic [NS-1:0] qualify(input logic [NS-1:0] q[$], input logic [NS-1:0] lvl);
        logic [NS-1:0] r = lvl;
        for (int b = 0; b < NS; b++) begin
            logic all_diff = (q.size() >= DB);
            for (int j = 0; j < DB && j < q.size(); j++)
                if (q[j][b] == lvl[b]) all_diff = 1'b0;
            if (all_diff) r[b] = ~lvl[b];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            {m_b1, m_b2, m_bdb, m_press, m_sticky} = '0;
            {m_s1, m_s2, m_sw, m_swprev} = '0;
            m_chg = 1'b0;
            bq.delete();
            sq.delete();
        end else begin
            bq.push_front(NS'(m_b2));
            if (bq.size() > DB) void'(bq.pop_back());
            m_nb     = NB'(qualify(bq, NS'(m_bdb)));
            m_press  = m_nb & ~m_bdb;
            m_sticky = (m_sticky & ~clr) | m_press;
            m_bdb    = m_nb;
`ifdef IO_SW_DEBOUNCE_EN
            sq.push_front(m_s2);
            if (sq.size() > DB) void'(sq.pop_back());
            m_nsw = qualify(sq, m_sw);
`else
            m_nsw = m_s1;
`endif
            m_old    = m_sw;
            m_chg    = (m_old != m_swprev);
            m_swprev = m_old;
            m_sw     = m_nsw;
            m_b2 = m_b1; m_b1 = btn_raw;
            m_s2 = m_s1; m_s1 = sw_raw;
        end
    end

    function automatic logic [VW-1:0] act_vec();
        return {io_btn, btn_press, btn_sticky, io_sw, sw_chg};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_bdb, m_press, m_sticky, m_sw, m_chg};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_raw = '1; sw_raw = '1; clr = '0;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== '0) begin
                errors++; $display("FAIL reset_hold got %h exp 0", act_vec());
            end
        end
        rst = 1'b0;
        for (int p = 1; p <= DB + 4; p++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_model p=%0d got %h exp %h", p, act_vec(), exp_vec());
            end
            checks++;
            if (p == 1 && act_vec() !== '0) begin
                errors++; $display("FAIL reset_first got %h exp 0", act_vec());
            end
            checks++;
            if (io_btn !== (p >= DB + 2 ? 4'hF : 4'h0) || btn_sticky !== (p >= DB + 2 ? 4'hF : 4'h0)) begin
                errors++; $display("FAIL reset_qual p=%0d btn %h sticky %h", p, io_btn, btn_sticky);
            end
        end
    endtask

    task automatic test_clean_press();
        btn_raw = '0; sw_raw = '0; clr = '1;
        step(DB + 4);
        clr = '0;
        btn_raw[0] = 1'b1;
        for (int p = 1; p <= 20; p++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL press_model p=%0d got %h exp %h", p, act_vec(), exp_vec());
            end
            checks++;
            if (io_btn[0] !== (p >= DB + 2) || btn_press[0] !== (p == DB + 2)) begin
                errors++; $display("FAIL press_lat p=%0d btn %b pulse %b", p, io_btn[0], btn_press[0]);
            end
        end
        checks++;
        if (btn_sticky[0] !== 1'b1) begin
            errors++; $display("FAIL press_sticky got %b exp 1", btn_sticky[0]);
        end
        btn_raw[0] = 1'b0;
        for (int p = 1; p <= DB + 4; p++) begin
            @(negedge clk);
            checks++;
            if (io_btn[0] !== (p < DB + 2) || btn_press[0] !== 1'b0) begin
                errors++; $display("FAIL release_lat p=%0d btn %b pulse %b", p, io_btn[0], btn_press[0]);
            end
        end
    endtask

    task automatic test_bounce();
        clr = '1;
        step(1);
        clr = '0;
        for (int c = 0; c < 40 + DB + 4; c++) begin
            btn_raw[1] = (c < 40) ? (c % 3 != 2) : 1'b0;
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL bounce_model c=%0d got %h exp %h", c, act_vec(), exp_vec());
            end
            checks++;
            if ({io_btn[1], btn_press[1], btn_sticky[1]} !== 3'b000) begin
                errors++; $display("FAIL bounce_leak c=%0d got %b exp 000", c, {io_btn[1], btn_press[1], btn_sticky[1]});
            end
        end
    endtask

    task automatic test_sticky_collision();
        btn_raw[2] = 1'b1;
        for (int p = 1; p <= DB + 5; p++) begin
            clr[2] = (p == DB + 2 || p == DB + 3);
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL collide_model p=%0d got %h exp %h", p, act_vec(), exp_vec());
            end
            if (p == DB + 2) begin
                checks++;
                if (btn_sticky[2] !== 1'b1) begin
                    errors++; $display("FAIL collide_set_wins got %b exp 1", btn_sticky[2]);
                end
            end
            if (p == DB + 3) begin
                checks++;
                if (btn_sticky[2] !== 1'b0) begin
                    errors++; $display("FAIL collide_clear got %b exp 0", btn_sticky[2]);
                end
            end
        end
        clr = '0;
        btn_raw = '0;
        step(DB + 4);
        btn_raw = 4'b1001;
        step(DB + 3);
        checks++;
        if (btn_sticky !== 4'b1001 || btn_sticky !== m_sticky) begin
            errors++; $display("FAIL dual_press sticky got %b exp 1001", btn_sticky);
        end
        btn_raw = '0;
        step(DB + 4);
    endtask

    task automatic test_switches();
        sw_raw = '0;
        step(DB + 4);
        sw_raw = 32'h0000_00A5;
        for (int p = 1; p <= DB + 4; p++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL sw_model p=%0d got %h exp %h", p, act_vec(), exp_vec());
            end
`ifndef IO_SW_DEBOUNCE_EN
            checks++;
            if (io_sw !== (p >= 2 ? 32'h0000_00A5 : 32'h0) || sw_chg !== (p == 3)) begin
                errors++; $display("FAIL sw_lat p=%0d sw %h chg %b", p, io_sw, sw_chg);
            end
`endif
        end
        for (int n = 0; n < 40; n++) begin
            sw_raw = (n % 4 == 0) ? sw_raw : $urandom;
            for (int h = 0; h < int'($urandom_range(3, 1)); h++) begin
                @(negedge clk);
                checks++;
                if (act_vec() !== exp_vec()) begin
                    errors++; $display("FAIL sw_rand n=%0d got %h exp %h", n, act_vec(), exp_vec());
                end
            end
        end
        sw_raw = '0;
        step(DB + 4);
    endtask

    task automatic test_reset_mid();
        btn_raw[0] = 1'b1;
        for (int p = 1; p <= DB + 12; p++) begin
            rst = (p == 8);
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL midrst_model p=%0d got %h exp %h", p, act_vec(), exp_vec());
            end
            checks++;
            if (io_btn[0] !== (p >= DB + 10)) begin
                errors++; $display("FAIL midrst_lat p=%0d got %b exp %b", p, io_btn[0], p >= DB + 10);
            end
        end
        rst = 1'b0;
        btn_raw = '0;
        step(DB + 4);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(11, 0) == 0) btn_raw[b] = ~btn_raw[b];
            clr = ($urandom_range(7, 0) == 0) ? NB'($urandom) : '0;
            if ($urandom_range(15, 0) == 0) sw_raw = $urandom;
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL random c=%0d got %h exp %h", c, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_sticky_collision();
        test_switches();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_input_cond.md
# io_input_cond

Input conditioning stage for the board I/O path, directly upstream of `singlecycle`'s `i_io_btn` / `i_io_sw` inputs. It synchronises raw asynchronous button and switch pins into `i_clk`, debounces buttons with a per-bit stable-count filter, and generates press pulses. It also keeps per-button sticky press flags, so firmware polling slowly never misses a press. Outputs feed the CPU's memory-mapped input registers unchanged in width.

## Interface
- `N_BTN`, default 4: number of push-buttons.
- `N_SW`, default 32: number of slide switches.
- `DB_CNT`, default 1000: consecutive stable cycles required before a debounced bit changes; legal range 2 .. 2^CNT_W-1.
- `CNT_W`, default 16: per-bit debounce counter width.

Ports:
- `i_clk`  in  1: clock; all state on the rising edge.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_btn_raw`  in  N_BTN: raw button pins, asynchronous, 1 = pressed.
- `i_sw_raw`  in  N_SW: raw switch pins, asynchronous.
- `o_io_btn`  out  N_BTN: debounced button level; connects to CPU `i_io_btn`.
- `o_io_sw`  out  N_SW: conditioned switch level; connects to CPU `i_io_sw`.
- `o_btn_press`  out  N_BTN: one-cycle pulse per debounced 0→1 transition.
- `o_btn_sticky`  out  N_BTN: latched press flags.
- `i_sticky_clr`  in  N_BTN: write-one-to-clear for `o_btn_sticky`.
- `o_sw_chg`  out  1: one-cycle pulse when any bit of `o_io_sw` changed.

## Operation
- **Synchroniser:** two-flop chain per bit (sync1, sync2) on every raw input. No logic between the flops.
- **Button debounce:** applies per bit, using counter `cnt` (CNT_W bits) and state `db`.
  - If sync2 == db: cnt ← 0.
  - If sync2 != db and cnt == DB_CNT-1: db ← sync2, cnt ← 0.
  - Otherwise: cnt ← cnt+1.
  - A single cycle of agreement restarts the count, so glitches shorter than DB_CNT cycles never propagate.
- **Press pulse:** `o_btn_press[i]` is registered. It is 1 in the cycle after an edge where db[i] went 0→1, and 0 otherwise. No pulse is generated on release.
- **Sticky:** sticky[i] ← (sticky[i] & ~i_sticky_clr[i]) | press_event[i]. When a set and a clear coincide, the set wins.
- **Switches:** `o_io_sw` = sync2 (see Configuration). `o_sw_chg` is a registered pulse, 1 for one cycle when `o_io_sw` differs from its value on the previous cycle.
- Bits are fully independent. Simultaneous events on several bits are each handled in full.

## Timing
- **Reset (`i_rst` = 1 at an edge):**
  - All sync flops, counters, db, sticky and pulse registers are cleared to 0.
  - Outputs `o_io_btn`, `o_io_sw`, `o_btn_press`, `o_btn_sticky` and `o_sw_chg` are all 0 from the following cycle.
  - A reset asserted mid-count discards the count. After reset release, a held-pressed button must be re-qualified for the full DB_CNT cycles.
- **Button latency:** raw stable from before edge k.
  - sync2 holds the new value after edge k+1.
  - db and `o_io_btn` update at edge k+DB_CNT+1.
  - `o_btn_press` is high for the single cycle following edge k+DB_CNT+1.
  - `o_btn_sticky` is set at the same edge.
- **Switch latency (macro undefined):** raw stable before edge k → `o_io_sw` valid after edge k+1, and `o_sw_chg` high after edge k+2 for one cycle.
- **Counter:** never exceeds DB_CNT-1, so no wrap occurs. DB_CNT outside the legal range is a configuration error and is flagged by an elaboration-time assertion.

## Configuration
- Macro: `IO_SW_DEBOUNCE_EN`.
- **Defined:** switches use the same debounce filter as buttons, with the same DB_CNT and their own per-bit counters. `o_io_sw` updates at edge k+DB_CNT+1 and `o_sw_chg` one edge later.
- **Undefined:** switches are synchronised only, with no switch counters instantiated. This is the default for area.

## Test plan
- **Reset:** drive raw inputs all-ones and hold `i_rst` = 1 for 3 cycles → every output is 0 during reset and on the first cycle after release. `o_io_btn` reaches 4'hF only DB_CNT+1 edges after release. Sticky bits are set only after that qualification.
- **Clean press (DB_CNT = 4):**
  - `i_btn_raw[0]` goes 0→1 before edge k → `o_io_btn[0]` = 1 and `o_btn_press[0]` = 1 after edge k+5.
  - The pulse lasts exactly 1 cycle and `o_btn_sticky[0]` = 1.
  - On release after 20 cycles: `o_io_btn[0]` = 0 after DB_CNT+1 edges, with no pulse.
- **Bounce (DB_CNT = 4):** toggle `i_btn_raw[1]` with a 3-cycle period for 40 cycles, then hold at 0 → `o_io_btn[1]`, `o_btn_press[1]` and `o_btn_sticky[1]` stay 0 throughout.
- **Sticky collision:**
  - Assert `i_sticky_clr[2]` = 1 in the same cycle as a press event on bit 2 → sticky[2] remains 1.
  - A clear one cycle later → sticky[2] = 0.
  - Pressing bits 0 and 3 together sets both flags.
- **Switches (macro undefined):** `i_sw_raw` = 32'h0000_00A5 before edge k → `o_io_sw` = 32'h0000_00A5 after edge k+1, and `o_sw_chg` = 1 for one cycle after edge k+2. With the macro defined, the same test gives `o_io_sw` after edge k+DB_CNT+1.
- **Reset mid-count (DB_CNT = 8):**
  - Hold a button pressed and pulse `i_rst` at count 5 → output stays 0.
  - After release of reset, the output rises exactly DB_CNT+1 edges later.
